shift_rot_pipe: RTL and testbench

- Parametrised, 2-stage pipelined barrel shifter/rotator for the execute datapath.
- Four modes: rotate left, shift left logical, rotate right, shift right logical. These cover ROL/SLL/ROR/SRL.
- Width N is a power of two. Count width C = log2(N).
- Valid/ready handshakes on input and output, so the block tolerates writeback stalls without dropping or duplicating results.

---
 rtl/shift_rot_pipe_if.sv | 25 ++
 rtl/shift_rot_pipe.sv | 109 ++++++++++
 tb/tb_shift_rot_pipe.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/shift_rot_pipe_if.sv
// Request/result bundle for shift_rot_pipe. The slave side is the shifter and the master side is the requester/consumer.
interface shift_rot_pipe_if #(
  parameter int N = 16,
  parameter int C = 4
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic [C-1:0] in_cnt;
  logic [1:0]   in_op;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
  logic         out_zero;

  modport slave (
    input  in_valid, in_data, in_cnt, in_op, out_ready,
    output in_ready, out_valid, out_data, out_zero
  );

  modport master (
    output in_valid, in_data, in_cnt, in_op, out_ready,
    input  in_ready, out_valid, out_data, out_zero
  );
endinterface

// File: rtl/shift_rot_pipe.sv
// shift_rot_pipe: a 2-stage ROL/SLL/ROR/SRL barrel shifter. Stage 1 applies the low count bits and stage 2 applies the high count bits.
// It has a latency of 2 cycles and a throughput of 1 per cycle. Valid/ready backpressure lets it buffer up to 2 results while stalled.
module shift_rot_pipe #(
  parameter int N = 16,
  parameter int C = 4,
  parameter int H = C / 2
) (
  input  logic            clk,
  input  logic            rst_n,
  shift_rot_pipe_if.slave bus
);

  localparam logic [1:0] OP_ROL = 2'b00;
  localparam logic [1:0] OP_SLL = 2'b01;
  localparam logic [1:0] OP_ROR = 2'b10;
  localparam logic [1:0] OP_SRL = 2'b11;

  generate
    if (N != (1 << C) || (C % 2) != 0 || C < 2 || H < 1 || H >= C) begin : g_bad_cfg
      $error("shift_rot_pipe: N must equal 2**C, C must be even and >= 2, and 1 <= H < C");
    end
  endgenerate

  // Each set count bit is one log-stage layer. The zero bits of the partial count pass the data through unchanged.
  function automatic logic [N-1:0] f_barrel(
    input logic [N-1:0] d,
    input logic [C-1:0] k,
    input logic [1:0]   op
  );
    logic [N-1:0]   v;
    logic [2*N-1:0] dd;
    v = d;
    for (int b = 0; b < C; b++) begin
      if (k[b]) begin
        dd = {v, v};
        case (op)
          OP_ROL:  v = dd[(2*N-1-(1<<b)) -: N];
          OP_SLL:  v = v << (1 << b);
          OP_ROR:  v = dd[(1<<b) +: N];
          OP_SRL:  v = v >> (1 << b);
          default: v = d;
        endcase
      end
    end
    return v;
  endfunction

  logic           r_v1;
  logic [N-1:0]   r_d1;
  logic [C-H-1:0] r_cnt_hi1;
  logic [1:0]     r_op1;
  logic           r_v2;
  logic [N-1:0]   r_d2;
  logic           r_zero2;

  logic           w_in_xfer;
  logic           w_out_xfer;
  logic           w_s1_adv;
  logic [C-1:0]   w_k1;
  logic [C-1:0]   w_k2;
  logic [N-1:0]   w_s1_res;
  logic [N-1:0]   w_s2_res;

  assign bus.in_ready = ~r_v1 | ~r_v2 | bus.out_ready;
  assign w_in_xfer    = bus.in_valid & bus.in_ready;
  assign w_out_xfer   = r_v2 & bus.out_ready;
  assign w_s1_adv     = r_v1 & (~r_v2 | bus.out_ready);

  assign w_k1     = {{(C-H){1'b0}}, bus.in_cnt[H-1:0]};
  assign w_k2     = {r_cnt_hi1, {H{1'b0}}};
  assign w_s1_res = f_barrel(bus.in_data, w_k1, bus.in_op);
  assign w_s2_res = f_barrel(r_d1, w_k2, r_op1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v1      <= 1'b0;
      r_d1      <= '0;
      r_cnt_hi1 <= '0;
      r_op1     <= '0;
    end else if (w_in_xfer) begin
      r_v1      <= 1'b1;
      r_d1      <= w_s1_res;
      r_cnt_hi1 <= bus.in_cnt[C-1:H];
      r_op1     <= bus.in_op;
    end else if (w_s1_adv) begin
      r_v1      <= 1'b0;
    end
  end

  // The zero flag is registered with the data so that out_zero carries no logic after the flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_v2    <= 1'b0;
      r_d2    <= '0;
      r_zero2 <= 1'b0;
    end else if (w_s1_adv) begin
      r_v2    <= 1'b1;
      r_d2    <= w_s2_res;
      r_zero2 <= (w_s2_res == '0);
    end else if (w_out_xfer) begin
      r_v2    <= 1'b0;
    end
  end

  assign bus.out_valid = r_v2;
  assign bus.out_data  = r_d2;
  assign bus.out_zero  = r_zero2;

endmodule

// File: tb/tb_shift_rot_pipe.sv
// Self-checking bench for shift_rot_pipe. It uses directed vectors, stall and reset sequences, and random traffic checked against a per-bit reference model.
module tb_shift_rot_pipe;
  localparam int N = 16;
  localparam int C = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  shift_rot_pipe_if #(.N(N), .C(C)) bus ();

  shift_rot_pipe #(.N(N), .C(C)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [N-1:0] data;
    logic [C-1:0] cnt;
    logic [1:0]   op;
    logic [N-1:0] exp;
  } vec_t;

  int           n_checks = 0;
  int           n_err    = 0;
  logic [N-1:0] sb [$];
  bit           prev_stall = 1'b0;
  logic [N-1:0] prev_data  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Each output bit is taken directly from the modular index definition of each mode.
  function automatic logic [N-1:0] ref_model(input logic [N-1:0] d, input int k, input logic [1:0] op);
    logic [N-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      case (op)
        2'b00: r[i] = d[(i - k + N) % N];
        2'b01: if (i >= k) r[i] = d[i - k];
        2'b10: r[i] = d[(i + k) % N];
        default: if (i + k < N) r[i] = d[i + k];
      endcase
    end
    return r;
  endfunction

  // One cycle. Call it at a negedge after setting the inputs. It samples, scores and returns at the next negedge.
  task automatic step(output bit acc, output bit oxf);
    logic [N-1:0] e;
    #1;
    acc = bus.in_valid && bus.in_ready;
    oxf = bus.out_valid && bus.out_ready;
    if (prev_stall) begin
      chk("hold_valid", 64'(bus.out_valid), 64'(1));
      chk("hold_data", 64'(bus.out_data), 64'(prev_data));
    end
    prev_stall = bus.out_valid && !bus.out_ready;
    prev_data  = bus.out_data;
    if (oxf) begin
      if (sb.size() == 0) begin
        n_checks++;
        n_err++;
        $display("FAIL spurious_out: got %0h expected no result at %0t", bus.out_data, $time);
      end else begin
        e = sb.pop_front();
        chk("out_data", 64'(bus.out_data), 64'(e));
        chk("out_zero", 64'(bus.out_zero), 64'(e == '0));
      end
    end
    if (acc) sb.push_back(ref_model(bus.in_data, int'(bus.in_cnt), bus.in_op));
    @(negedge clk);
  endtask

  // A single isolated request with exact latency checks. It starts and ends at a negedge with the pipe empty.
  task automatic run_vec(input vec_t v);
    bus.in_valid  = 1'b1;
    bus.in_data   = v.data;
    bus.in_cnt    = v.cnt;
    bus.in_op     = v.op;
    bus.out_ready = 1'b1;
    #1 chk("vec_in_ready", 64'(bus.in_ready), 64'(1));
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.in_data  = N'($urandom);
    bus.in_cnt   = C'($urandom_range(0, N - 1));
    #1 chk("vec_lat1_valid", 64'(bus.out_valid), 64'(0));
    @(negedge clk);
    #1;
    chk("vec_valid", 64'(bus.out_valid), 64'(1));
    chk("vec_data", 64'(bus.out_data), 64'(v.exp));
    chk("vec_zero", 64'(bus.out_zero), 64'(v.exp == '0));
    @(negedge clk);
  endtask

  vec_t vecs [16];

  initial begin
    bit   acc, oxf;
    int   n_acc, n_out;
    vec_t v;

    vecs[0]  = '{16'h8001, 4'd1,  2'b00, 16'h0003};
    vecs[1]  = '{16'h0001, 4'd1,  2'b10, 16'h8000};
    vecs[2]  = '{16'h1234, 4'd8,  2'b00, 16'h3412};
    vecs[3]  = '{16'h8001, 4'd4,  2'b01, 16'h0010};
    vecs[4]  = '{16'hF000, 4'd12, 2'b11, 16'h000F};
    vecs[5]  = '{16'h0008, 4'd4,  2'b11, 16'h0000};
    vecs[6]  = '{16'hA5C3, 4'd0,  2'b00, 16'hA5C3};
    vecs[7]  = '{16'hA5C3, 4'd0,  2'b01, 16'hA5C3};
    vecs[8]  = '{16'hA5C3, 4'd0,  2'b10, 16'hA5C3};
    vecs[9]  = '{16'hA5C3, 4'd0,  2'b11, 16'hA5C3};
    vecs[10] = '{16'h1234, 4'd4,  2'b10, 16'h4123};
    vecs[11] = '{16'h8000, 4'd15, 2'b11, 16'h0001};
    vecs[12] = '{16'h0001, 4'd15, 2'b01, 16'h8000};
    vecs[13] = '{16'h8000, 4'd15, 2'b00, 16'h4000};
    vecs[14] = '{16'hFFFF, 4'd5,  2'b01, 16'hFFE0};
    vecs[15] = '{16'hFFFF, 4'd3,  2'b11, 16'h1FFF};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.in_cnt    = '0;
    bus.in_op     = '0;
    bus.out_ready = 1'b0;
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_out_data", 64'(bus.out_data), 64'(0));
    chk("rst_out_zero", 64'(bus.out_zero), 64'(0));
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) run_vec(vecs[i]);

    // The back-to-back stream: 8 requests produce 8 results on cycles 2..9.
    bus.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bus.in_valid = (i < 8);
      bus.in_data  = N'($urandom);
      bus.in_cnt   = C'($urandom_range(0, N - 1));
      bus.in_op    = 2'($urandom_range(0, 3));
      step(acc, oxf);
      if (i < 8) chk("b2b_in_ready", 64'(acc), 64'(1));
      chk("b2b_out_cycle", 64'(oxf), 64'(i >= 2 && i < 10));
    end

    // Stall: only two requests fit while the consumer is blocked.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = N'($urandom);
      bus.in_cnt   = C'($urandom_range(0, N - 1));
      bus.in_op    = 2'($urandom_range(0, 3));
      step(acc, oxf);
      chk("stall_in_ready", 64'(acc), 64'(i < 2));
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    n_out = 0;
    for (int i = 0; i < 10; i++) begin
      step(acc, oxf);
      if (oxf) n_out++;
    end
    chk("stall_drained", 64'(n_out), 64'(2));
    chk("stall_sb_empty", 64'(sb.size()), 64'(0));

    // Asynchronous reset between edges with both stages full.
    bus.out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 16'hFFFF;
      bus.in_cnt   = C'(i);
      bus.in_op    = 2'b00;
      step(acc, oxf);
    end
    bus.in_valid = 1'b0;
    #1;
    chk("full_before_rst", 64'(bus.out_valid), 64'(1));
    #1 rst_n = 1'b0;
    #1;
    chk("arst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("arst_out_data", 64'(bus.out_data), 64'(0));
    chk("arst_in_ready", 64'(bus.in_ready), 64'(1));
    sb.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst_n         = 1'b1;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(acc, oxf);
      chk("post_rst_idle", 64'(oxf), 64'(0));
    end
    v.data = 16'hC3A5;
    v.cnt  = 4'd7;
    v.op   = 2'b10;
    v.exp  = ref_model(v.data, 7, 2'b10);
    run_vec(v);

    // Random traffic with random backpressure.
    n_acc = 0;
    for (int cyc = 0; cyc < 60000 && n_acc < 10000; cyc++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.out_ready = ($urandom_range(0, 3) != 0);
      bus.in_data   = N'($urandom);
      bus.in_cnt    = C'($urandom_range(0, N - 1));
      bus.in_op     = 2'($urandom_range(0, 3));
      step(acc, oxf);
      if (acc) n_acc++;
    end
    chk("rand_accepts", 64'(n_acc), 64'(10000));
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int cyc = 0; cyc < 10 && sb.size() != 0; cyc++) step(acc, oxf);
    chk("rand_drained", 64'(sb.size()), 64'(0));

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
